// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions: instruction field layout, reset PC and fetch FSM encodings.
// Imported by the fetch stage and by the control unit that decodes opcode/funct.
package fetch_stage_pkg;

  localparam int unsigned CPU_PC_W     = 8;
  localparam int unsigned CPU_INSTR_W  = 16;
  localparam int unsigned CPU_RESET_PC = 0;

  // opcode occupies the top OPCODE_W bits of the word, funct the bottom FUNCT_W bits
  localparam int unsigned OPCODE_W  = 4;
  localparam int unsigned FUNCT_W   = 3;
  localparam int unsigned FUNCT_LSB = 0;

  // A bubble decodes as R-type ADD, which the control unit treats as no writeback
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 4'h0;
  localparam logic [FUNCT_W-1:0]  FUNCT_ADD = 3'h0;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears the live bit, stall freezes everything,
// otherwise it loads the offered word or becomes a bubble.
module if_id_reg #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= load_i;
      if (load_i) begin
        instr_q <= instr_i;
        pc_q    <= pc_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding instruction-memory request FSM, one-entry
// skid buffer and the IF/ID register feeding the control unit.
//
//   state   | meaning
//   FS_IDLE | no request outstanding; issue one for pc on the next edge
//   FS_WAIT | request outstanding, imem_req/imem_addr held until imem_valid
//   FS_HOLD | returned word parked in the skid buffer while decode is stalled
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W     = CPU_PC_W,
  parameter int unsigned INSTR_W  = CPU_INSTR_W,
  parameter int unsigned RESET_PC = CPU_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                stall,
  input  logic                pcsrc,
  input  logic [PC_W-1:0]     target_pc,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [PC_W-1:0]     if_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNCT_W-1:0]  funct
);

  localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

  fetch_state_e       state_q;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_d;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    addr_q;
  logic               req_q;
  logic               drop_q;
  logic [INSTR_W-1:0] skid_q;

  logic               id_load;
  logic [INSTR_W-1:0] id_instr;

  assign pc_inc = pc_q + PC_W'(1);

  // A redirect always wins; otherwise pc advances only when a word is handed to IF/ID
  always_comb begin
    pc_d = pc_q;
    if (pcsrc) begin
      pc_d = target_pc;
    end else begin
      case (state_q)
        FS_WAIT: if (imem_valid && !drop_q && !stall) pc_d = pc_inc;
        FS_HOLD: if (!stall) pc_d = pc_inc;
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RST_PC;
      addr_q  <= RST_PC;
      req_q   <= 1'b0;
      drop_q  <= 1'b0;
      skid_q  <= '0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        FS_IDLE: begin
          req_q   <= 1'b1;
          addr_q  <= pc_d;
          drop_q  <= 1'b0;
          state_q <= FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_valid) begin
            drop_q <= 1'b0;
            if (!pcsrc && !drop_q && stall) begin
              skid_q  <= imem_rdata;
              req_q   <= 1'b0;
              state_q <= FS_HOLD;
            end else begin
              // accepted, dropped or redirected: the next request goes out at once
              req_q  <= 1'b1;
              addr_q <= pc_d;
            end
          end else if (pcsrc) begin
            drop_q <= 1'b1;
          end
        end
        FS_HOLD: begin
          if (pcsrc) begin
            skid_q  <= '0;
            req_q   <= 1'b1;
            addr_q  <= pc_d;
            state_q <= FS_WAIT;
          end else if (!stall) begin
            skid_q  <= '0;
            state_q <= FS_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= FS_IDLE;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  // In both load cases pc_q is still the address of the word being delivered
  assign id_load  = ((state_q == FS_WAIT) && imem_valid && !drop_q) || (state_q == FS_HOLD);
  assign id_instr = (state_q == FS_HOLD) ? skid_q : imem_rdata;

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall),
    .flush_i (pcsrc),
    .load_i  (id_load),
    .instr_i (id_instr),
    .pc_i    (pc_q),
    .valid_o (if_valid),
    .instr_o (if_instr),
    .pc_o    (if_pc)
  );

  assign opcode = if_valid ? if_instr[INSTR_W-1 -: OPCODE_W] : OP_RTYPE;
  assign funct  = if_valid ? if_instr[FUNCT_LSB +: FUNCT_W]  : FUNCT_ADD;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: variable-latency memory model, stall, redirect,
// PC wrap and mid-request reset, each scenario started from a fresh reset.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_valid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall = 1'b0;
  logic               pcsrc = 1'b0;
  logic [PC_W-1:0]    target_pc = '0;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic [3:0]         opcode;
  logic [2:0]         funct;

  int checks   = 0;
  int failures = 0;

  // memory: answers in the lat-th cycle a request is visible; word = {addr^A5, addr}
  int   lat       = 1;
  int   cnt       = 0;
  logic force_vld = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst)                      cnt <= 0;
    else if (!imem_req || imem_valid) cnt <= 0;
    else                          cnt <= cnt + 1;
  end

  assign imem_valid = force_vld | (imem_req && (cnt == lat - 1));
  assign imem_rdata = {imem_addr ^ 8'hA5, imem_addr};

  fetch_stage #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .pcsrc      (pcsrc),
    .target_pc  (target_pc),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .opcode     (opcode),
    .funct      (funct)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // leaves the bench at the negedge where rst falls
  task automatic do_reset();
    rst       = 1'b1;
    stall     = 1'b0;
    pcsrc     = 1'b0;
    target_pc = '0;
    force_vld = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset values
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req",    imem_req,  0);
    chk("rst_addr",   imem_addr, 0);
    chk("rst_valid",  if_valid,  0);
    chk("rst_instr",  if_instr,  0);
    chk("rst_pc",     if_pc,     0);
    chk("rst_opcode", opcode,    0);
    chk("rst_funct",  funct,     0);

    // single-cycle memory: back-to-back fetches
    lat = 1;
    do_reset();
    tick();
    chk("a_first_req",  imem_req,  1);
    chk("a_first_addr", imem_addr, 0);
    chk("a_not_yet",    if_valid,  0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("a_if_valid", if_valid, 1);
      chk("a_if_pc",    if_pc,    k);
    end
    chk("a_instr3", if_instr, 16'hA603);
    chk("a_opcode", opcode,   4'hA);
    chk("a_funct",  funct,    3'h3);

    // three-cycle memory
    lat = 3;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("b_req",      imem_req,  1);
      chk("b_addr",     imem_addr, k / 3);
      chk("b_if_valid", if_valid,  (k % 3 == 0) && (k > 0));
      if ((k % 3 == 0) && (k > 0)) chk("b_if_pc", if_pc, k / 3 - 1);
    end

    // stall for four edges as word 1 returns
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("c_pre_pc", if_pc, 0);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("c_hold_req",     imem_req, 0);
      chk("c_frozen_pc",    if_pc,    0);
      chk("c_frozen_instr", if_instr, 16'hA500);
      chk("c_frozen_valid", if_valid, 1);
    end
    stall = 1'b0;
    tick();
    chk("c_release_pc",    if_pc,    1);
    chk("c_release_instr", if_instr, 16'hA401);
    chk("c_release_valid", if_valid, 1);
    tick();
    chk("c_bubble_valid",  if_valid, 0);
    chk("c_bubble_opcode", opcode,   0);
    chk("c_restart_req",   imem_req, 1);
    chk("c_restart_addr",  imem_addr, 2);
    tick();
    chk("c_next_valid", if_valid, 1);
    chk("c_next_pc",    if_pc,    2);

    // redirect while a request is pending, stall high to check flush priority
    lat = 3;
    do_reset();
    repeat (4) tick();
    chk("d_pre_valid", if_valid, 1);
    pcsrc     = 1'b1;
    target_pc = 8'h40;
    stall     = 1'b1;
    tick();
    chk("d_flush_valid",  if_valid,  0);
    chk("d_pending_addr", imem_addr, 1);
    chk("d_pending_req",  imem_req,  1);
    pcsrc = 1'b0;
    stall = 1'b0;
    tick();
    chk("d_stale_addr", imem_addr, 1);
    tick();
    chk("d_redirect_addr", imem_addr, 8'h40);
    chk("d_drop_valid",    if_valid,  0);
    tick();
    tick();
    chk("d_wait_valid", if_valid, 0);
    tick();
    chk("d_target_valid",  if_valid, 1);
    chk("d_target_pc",     if_pc,    8'h40);
    chk("d_target_instr",  if_instr, 16'hE540);
    chk("d_target_opcode", opcode,   4'hE);

    // redirect coinciding with returning data, then fetch at 0xFF wraps
    lat = 1;
    do_reset();
    tick();
    pcsrc     = 1'b1;
    target_pc = 8'hFF;
    tick();
    pcsrc = 1'b0;
    chk("e_redirect_addr", imem_addr, 8'hFF);
    chk("e_discard_valid", if_valid,  0);
    tick();
    chk("e_wrap_valid",  if_valid,  1);
    chk("e_wrap_pc",     if_pc,     8'hFF);
    chk("e_wrap_addr",   imem_addr, 8'h00);
    chk("e_wrap_instr",  if_instr,  16'h5AFF);
    chk("e_wrap_opcode", opcode,    4'h5);
    chk("e_wrap_funct",  funct,     3'h7);
    tick();
    chk("e_after_wrap_pc", if_pc, 8'h00);

    // reset mid-request, stray valid right after release
    lat = 3;
    do_reset();
    repeat (4) tick();
    chk("f_pre_valid", if_valid, 1);
    rst = 1'b1;
    #1;
    chk("f_rst_req",    imem_req,  0);
    chk("f_rst_addr",   imem_addr, 0);
    chk("f_rst_valid",  if_valid,  0);
    chk("f_rst_pc",     if_pc,     0);
    chk("f_rst_instr",  if_instr,  0);
    chk("f_rst_opcode", opcode,    0);
    tick();
    rst       = 1'b0;
    force_vld = 1'b1;
    tick();
    force_vld = 1'b0;
    chk("f_restart_req",   imem_req,  1);
    chk("f_restart_addr",  imem_addr, 0);
    chk("f_ignored_valid", if_valid,  0);
    tick();
    chk("f_still_empty", if_valid, 0);
    tick();
    tick();
    chk("f_restart_valid", if_valid, 1);
    chk("f_restart_pc",    if_pc,    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
